// File: rtl/cbb_stream_pkg.sv
// Shared stream definitions: beat payload type and bwdpipe limits.
`ifndef CBB_STREAM_BEAT_T
`define CBB_STREAM_BEAT_T(W) struct packed { logic valid; logic [(W)-1:0] data; }
`endif

package cbb_stream_pkg;

  localparam int unsigned BWDPIPE_MAX_STAGES = 8;

endpackage

// File: rtl/bwdpipe_stage.sv
// One ready-path skid stage: s_ready comes straight from a flop, a beat that
// arrives while downstream stalls is parked in the skid register.
module bwdpipe_stage
  import cbb_stream_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DWIDTH-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid_c,
  output logic [DWIDTH-1:0] m_data_c,
  input  logic              m_ready,
  output logic              skid_vld_nxt_c
);

  logic              skid_vld_q, skid_vld_d;
  logic              rdy_q, rdy_d;
  logic [DWIDTH-1:0] skid_data_q, skid_data_d;
  logic              capture;

  // Pass-through is gated by rdy_q so a beat offered while the stage is still
  // coming out of reset cannot reach downstream without being accepted here.
  always_comb begin
    capture     = s_valid & rdy_q & ~m_ready & ~skid_vld_q;
    skid_vld_d  = skid_vld_q ? ~m_ready : capture;
    rdy_d       = ~skid_vld_d;
    skid_data_d = capture ? s_data : skid_data_q;
    m_valid_c   = skid_vld_q | (s_valid & rdy_q);
    m_data_c    = skid_vld_q ? skid_data_q : s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  // Payload holds no reset; it is only meaningful while skid_vld_q is set.
  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
  end

  assign s_ready        = rdy_q;
  assign skid_vld_nxt_c = skid_vld_d;

endmodule

// File: rtl/bwdpipe.sv
// Backward pipeline: STAGES chained skid stages that register the ready path,
// plus a registered count of occupied skid registers.
module bwdpipe
  import cbb_stream_pkg::*;
#(
  parameter  int unsigned DWIDTH = 32,
  parameter  int unsigned STAGES = 1,
  localparam int unsigned CNTW   = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DWIDTH-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DWIDTH-1:0] m_data,
  input  logic              m_ready,
  output logic [CNTW-1:0]   occupancy
);

  typedef `CBB_STREAM_BEAT_T(DWIDTH) stream_beat_t;

  if (STAGES < 1 || STAGES > BWDPIPE_MAX_STAGES) begin : g_bad_stages
    $error("bwdpipe: STAGES=%0d outside 1..%0d", STAGES, BWDPIPE_MAX_STAGES);
  end

  logic [STAGES-1:0] vld_nxt;
  logic [CNTW-1:0]   occupancy_q, occupancy_d;

  // Each stage owns its link signals so the combinational valid/data chain
  // never folds back onto a single shared variable.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    stream_beat_t s_beat;
    stream_beat_t m_beat;
    logic         s_rdy;
    logic         m_rdy;

    if (i == 0) begin : g_head
      assign s_beat = '{valid: s_valid, data: s_data};
    end else begin : g_link
      assign s_beat = g_stage[i-1].m_beat;
    end

    if (i == STAGES - 1) begin : g_tail
      assign m_rdy = m_ready;
    end else begin : g_mid
      assign m_rdy = g_stage[i+1].s_rdy;
    end

    bwdpipe_stage #(
      .DWIDTH(DWIDTH)
    ) u_stage (
      .clk           (clk),
      .rst           (rst),
      .s_valid       (s_beat.valid),
      .s_data        (s_beat.data),
      .s_ready       (s_rdy),
      .m_valid_c     (m_beat.valid),
      .m_data_c      (m_beat.data),
      .m_ready       (m_rdy),
      .skid_vld_nxt_c(vld_nxt[i])
    );
  end

  assign s_ready = g_stage[0].s_rdy;
  assign m_valid = g_stage[STAGES-1].m_beat.valid;
  assign m_data  = g_stage[STAGES-1].m_beat.data;

  // Occupancy tracks the skid flags as they will be after this edge.
  always_comb begin
    occupancy_d = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      occupancy_d = occupancy_d + CNTW'(vld_nxt[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy_q <= '0;
    end else begin
      occupancy_q <= occupancy_d;
    end
  end

  assign occupancy = occupancy_q;

endmodule
